// File: rtl/jam_cost_table_pkg.sv
// ----------------------------------------------------------------------------
// jam_cost_table_pkg
// Shared constants, types and helpers for the Job Assignment Machine cost store.
//   N       : workers = jobs (table holds N*N entries)
//   COST_W  : width of one cost entry
//   SUM_W   : width of the lower-bound sum (N*(2^COST_W-1) < 2^SUM_W)
//   IDX_W   : width of the row-major load index
//   JW      : width of one worker / job index
// ----------------------------------------------------------------------------
package jam_cost_table_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned COST_W = 7;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned JW     = 3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N * N - 1);
    localparam logic [JW-1:0]    J_LAST   = JW'(N - 1);

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    function automatic logic [COST_W-1:0] min_cost(input logic [COST_W-1:0] a,
                                                   input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_cost_table_if.sv
// ----------------------------------------------------------------------------
// jam_cost_table_if
// Valid/ready load stream carrying the cost matrix in row-major order.
//   in_valid : beat valid (master -> slave)
//   in_ready : beat accepted when in_valid && in_ready (slave -> master)
//   in_data  : cost for entry idx = W*N + J
//   in_last  : high on the final beat only
// Modports: master (stream source), slave (cost table).
// ----------------------------------------------------------------------------
interface jam_cost_table_if;
    import jam_cost_table_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [COST_W-1:0] in_data;
    logic              in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/jam_cost_table_mem.sv
// ----------------------------------------------------------------------------
// jam_cost_table_mem
// DEPTH x DATA_W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   CLK   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// ----------------------------------------------------------------------------
module jam_cost_table_mem #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 7
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_table.sv
// ----------------------------------------------------------------------------
// jam_cost_table
// Upstream cost store for the Job Assignment Machine. Loads an N x N cost
// matrix over a valid/ready stream (row-major), then serves zero-latency
// lookups Cost = table[W*N+J]. Flags in_last framing errors (sticky).
// Optional macro JAM_LOWER_BOUND_EN adds LowerBound = sum of row minima;
// with the macro undefined LowerBound is tied to 0.
//   CLK         : clock, rising edge
//   RST         : synchronous active-high reset
//   in_if       : load stream (slave modport)
//   reload      : pulse, discard table and restart the load
//   table_valid : table complete, lookups legal
//   load_err    : sticky framing error
//   W, J        : lookup worker / job index
//   Cost        : looked-up cost, 0 while table_valid is low
//   LowerBound  : sum of row minima, 0 while table_valid is low
// ----------------------------------------------------------------------------
module jam_cost_table
    import jam_cost_table_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    jam_cost_table_if.slave      in_if,
    input  logic                 reload,
    output logic                 table_valid,
    output logic                 load_err,
    input  logic [JW-1:0]        W,
    input  logic [JW-1:0]        J,
    output logic [COST_W-1:0]    Cost,
    output logic [SUM_W-1:0]     LowerBound
);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              last_idx;
    logic [COST_W-1:0] rd_cost;

    // reload takes priority: a beat presented with reload is never accepted.
    assign in_if.in_ready = (state == S_LOAD) && !reload;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign last_idx       = (idx == IDX_LAST);

    always_ff @(posedge CLK) begin
        if (RST || reload) begin
            state       <= S_LOAD;
            idx         <= '0;
            table_valid <= 1'b0;
            load_err    <= 1'b0;
        end else if (accept) begin
            // Completion follows idx only; in_last just feeds the error flag.
            idx <= last_idx ? '0 : idx + 1'b1;
            if (in_if.in_last != last_idx) begin
                load_err <= 1'b1;
            end
            if (last_idx) begin
                state       <= S_SERVE;
                table_valid <= 1'b1;
            end
        end
    end

    jam_cost_table_mem #(
        .DEPTH  (N * N),
        .ADDR_W (IDX_W),
        .DATA_W (COST_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (accept),
        .waddr (idx),
        .wdata (in_if.in_data),
        .raddr ({W, J}),
        .rdata (rd_cost)
    );

    assign Cost = table_valid ? rd_cost : '0;

`ifdef JAM_LOWER_BOUND_EN
    logic [JW-1:0]     beat_j;
    logic [COST_W-1:0] row_min;
    logic [COST_W-1:0] row_min_nxt;
    logic [SUM_W-1:0]  lb_acc;

    assign beat_j = idx[JW-1:0];

    // First beat of a row seeds the minimum; later beats fold in.
    always_comb begin
        row_min_nxt = in_if.in_data;
        if (beat_j != '0) begin
            row_min_nxt = min_cost(row_min, in_if.in_data);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || reload) begin
            row_min <= '0;
            lb_acc  <= '0;
        end else if (accept) begin
            row_min <= row_min_nxt;
            if (beat_j == J_LAST) begin
                lb_acc <= lb_acc + SUM_W'(row_min_nxt);
            end
        end
    end

    assign LowerBound = table_valid ? lb_acc : '0;
`else
    assign LowerBound = '0;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// ----------------------------------------------------------------------------
// tb_jam_cost_table
// Directed bench for jam_cost_table with a behavioural table model checked
// every cycle, plus literal expectations for the key scenarios.
// ----------------------------------------------------------------------------
module tb_jam_cost_table;
    import jam_cost_table_pkg::*;

    logic              CLK = 1'b0;
    logic              RST;
    logic              reload;
    logic              table_valid;
    logic              load_err;
    logic [JW-1:0]     W;
    logic [JW-1:0]     J;
    logic [COST_W-1:0] Cost;
    logic [SUM_W-1:0]  LowerBound;

    jam_cost_table_if bus ();

    jam_cost_table dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_if       (bus),
        .reload      (reload),
        .table_valid (table_valid),
        .load_err    (load_err),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .LowerBound  (LowerBound)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int pat [64];

    // Model: a load gathers 64 accepted beats into m_tab, then the table is live.
    int m_tab [64];
    int m_count = 0;
    bit m_load  = 1'b1;
    bit m_valid = 1'b0;
    bit m_err   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sum_row_min();
        int s = 0;
        for (int w = 0; w < 8; w++) begin
            int m = m_tab[w*8];
            for (int j = 1; j < 8; j++) if (m_tab[w*8+j] < m) m = m_tab[w*8+j];
            s += m;
        end
        return s;
    endfunction

    always @(posedge CLK) begin
        if (RST || reload) begin
            m_load  <= 1'b1;
            m_count <= 0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_load && bus.in_valid) begin
            m_tab[m_count] <= int'(bus.in_data);
            if (bus.in_last != (m_count == 63)) m_err <= 1'b1;
            if (m_count == 63) begin
                m_load  <= 1'b0;
                m_valid <= 1'b1;
                m_count <= 0;
            end else begin
                m_count <= m_count + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            int exp_lb;
            exp_lb = 0;
`ifdef JAM_LOWER_BOUND_EN
            if (m_valid) exp_lb = sum_row_min();
`endif
            chk("mon_in_ready",    int'(bus.in_ready), int'(m_load && !reload));
            chk("mon_table_valid", int'(table_valid),  int'(m_valid));
            chk("mon_load_err",    int'(load_err),     int'(m_err));
            chk("mon_cost",        int'(Cost),         m_valid ? m_tab[int'(W)*8 + int'(J)] : 0);
            chk("mon_lower_bound", int'(LowerBound),   exp_lb);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int data, input bit last);
        bus.in_valid = 1'b1;
        bus.in_data  = COST_W'(data);
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Beats [from, to] of pat, optional random idle gaps, in_last at last_at.
    task automatic load_range(input int from, input int to, input int last_at, input bit gaps);
        for (int i = from; i <= to; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) tick();
            end
            W = JW'(i / 8);
            J = JW'(i % 8);
            send(pat[i], i == last_at);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic lookup(input int w, input int j);
        W = JW'(w);
        J = JW'(j);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; reload = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        W = '0; J = '0;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_table_valid", int'(table_valid), 0);
        chk("reset_load_err",    int'(load_err), 0);
        chk("reset_cost",        int'(Cost), 0);
        chk("reset_lower_bound", int'(LowerBound), 0);
        RST = 1'b0;
        tick();

        // 1: cost = W+J, gapless
        for (int i = 0; i < 64; i++) pat[i] = i / 8 + i % 8;
        load_range(0, 62, 63, 1'b0);
        chk("t1_valid_before_last", int'(table_valid), 0);
        load_range(63, 63, 63, 1'b0);
        chk("t1_valid_after_last", int'(table_valid), 1);
        lookup(3, 5);
        chk("t1_cost_3_5", int'(Cost), 8);
        chk("t1_load_err", int'(load_err), 0);
`ifdef JAM_LOWER_BOUND_EN
        chk("t1_lower_bound", int'(LowerBound), 28);
`else
        chk("t1_lower_bound", int'(LowerBound), 0);
`endif

        // 2: same table with random gaps; beats ignored while serving
        do_reload();
        load_range(0, 63, 63, 1'b1);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) begin
                lookup(w, j);
                chk("t2_table", int'(Cost), w + j);
            end
        bus.in_valid = 1'b1; bus.in_data = 7'd99;
        #1;
        chk("t2_ready_in_serve", int'(bus.in_ready), 0);
        tick();
        bus.in_valid = 1'b0;
        lookup(0, 0);
        chk("t2_cost_untouched", int'(Cost), 0);

        // 3: in_last on beat 10
        do_reload();
        load_range(0, 63, 10, 1'b0);
        chk("t3_load_err", int'(load_err), 1);
        chk("t3_table_valid", int'(table_valid), 1);
        do_reload();
        chk("t3_err_cleared", int'(load_err), 0);
        chk("t3_valid_cleared", int'(table_valid), 0);

        // 4: reload together with beat 20
        for (int i = 0; i < 64; i++) pat[i] = (i * 3) % 128;
        load_range(0, 19, 63, 1'b0);
        reload = 1'b1; bus.in_valid = 1'b1; bus.in_data = 7'd77;
        tick();
        reload = 1'b0; bus.in_valid = 1'b0;
        load_range(0, 62, 63, 1'b0);
        chk("t4_valid_after_63", int'(table_valid), 0);
        load_range(63, 63, 63, 1'b0);
        chk("t4_valid_after_64", int'(table_valid), 1);
        lookup(2, 4);
        chk("t4_cost_2_4", int'(Cost), 60);
        chk("t4_load_err", int'(load_err), 0);

        // 5: RST mid-load, then a fresh load
        do_reload();
        for (int i = 0; i < 64; i++) pat[i] = ((i / 8) * 13 + (i % 8) * 5) % 128;
        load_range(0, 39, 63, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        lookup(7, 7);
        chk("t5_valid_after_rst", int'(table_valid), 0);
        chk("t5_cost_after_rst", int'(Cost), 0);
        load_range(0, 63, 63, 1'b0);
        lookup(7, 7);
        chk("t5_cost_7_7", int'(Cost), 126);
        chk("t5_valid", int'(table_valid), 1);

        // 6: lower bound patterns
        do_reload();
        for (int i = 0; i < 64; i++) pat[i] = (i / 8 == i % 8) ? 0 : 100;
        load_range(0, 63, 63, 1'b0);
        chk("t6_lb_diag_zero", int'(LowerBound), 0);
        do_reload();
        for (int i = 0; i < 64; i++) pat[i] = 127;
        load_range(0, 63, 63, 1'b0);
`ifdef JAM_LOWER_BOUND_EN
        chk("t6_lb_all_127", int'(LowerBound), 1016);
`else
        chk("t6_lb_all_127", int'(LowerBound), 0);
`endif
        do_reload();
        chk("t6_lb_after_reload", int'(LowerBound), 0);
        for (int i = 0; i < 64; i++) pat[i] = (i / 8) + 1 + (7 - i % 8);
        load_range(0, 63, 63, 1'b0);
`ifdef JAM_LOWER_BOUND_EN
        chk("t6_lb_row_min", int'(LowerBound), 36);
`else
        chk("t6_lb_row_min", int'(LowerBound), 0);
`endif

        tick(); tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
